// File: rtl/led_fade_pwm.sv
// led_fade_pwm: six-channel PWM output stage that fades each active-low LED
// bit toward fully on or fully off instead of switching it hard.
// All channels share one duty-step timer and one 255-cycle PWM counter.

module led_fade_pwm #(
    parameter int unsigned STEP_DIV = 98039
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] led_i,
    input  logic       fade_en,
    output logic [5:0] led_o,
    output logic       busy
);

    localparam logic [23:0] STEP_LAST = 24'(STEP_DIV - 1);

    logic [5:0]      led_q;
    logic [23:0]     step_cnt;
    logic            step_tick;
    logic [7:0]      pwm_cnt;
    logic [5:0][7:0] duty;
    logic [5:0][7:0] target;

    // Lit input bit (0) asks for full brightness, dark bit for zero.
    always_comb begin
        target = '0;
        for (int n = 0; n < 6; n++) begin
            target[n] = led_q[n] ? 8'd0 : 8'd255;
        end
    end

    assign step_tick = (step_cnt == STEP_LAST);

    // Busy while any channel is still away from its target.
    always_comb begin
        busy = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (duty[n] != target[n]) busy = 1'b1;
        end
    end

    // Input register for the generator pattern.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) led_q <= 6'b111111;
        else       led_q <= led_i;
    end

    // Free-running duty-step timer; one tick per STEP_DIV cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          step_cnt <= '0;
        else if (step_tick) step_cnt <= '0;
        else                step_cnt <= step_cnt + 24'd1;
    end

    // Free-running PWM counter, 0..254, so duty 255 means always on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  pwm_cnt <= '0;
        else if (pwm_cnt == 8'd254) pwm_cnt <= '0;
        else                        pwm_cnt <= pwm_cnt + 8'd1;
    end

    // Duty update: snap when fading is off, else one step per tick toward target.
    // Targets are only 0 or 255, so stepping toward them can never wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            duty <= '0;
        end else begin
            for (int n = 0; n < 6; n++) begin
                if (!fade_en) begin
                    duty[n] <= target[n];
                end else if (step_tick) begin
                    if (duty[n] < target[n])      duty[n] <= duty[n] + 8'd1;
                    else if (duty[n] > target[n]) duty[n] <= duty[n] - 8'd1;
                end
            end
        end
    end

    // Registered active-low PWM drive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_o <= 6'b111111;
        end else begin
            for (int n = 0; n < 6; n++) begin
                led_o[n] <= ~(pwm_cnt < duty[n]);
            end
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with a short step divider. A behavioural model
// derives timer and PWM phases from the edge count since reset.

module tb_led_fade_pwm;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] led_i;
    logic       fade_en;
    logic [5:0] led_o;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_edges;
    logic [5:0] m_led_q;
    logic [5:0] m_led_o;
    int         m_duty[6];

    led_fade_pwm #(.STEP_DIV(SD)) dut (
        .clk(clk), .rstn(rstn), .led_i(led_i), .fade_en(fade_en),
        .led_o(led_o), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int tgt(int n);
        return m_led_q[n] ? 0 : 255;
    endfunction

    function automatic logic m_busy();
        for (int n = 0; n < 6; n++) if (m_duty[n] != tgt(n)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_led_q = 6'b111111;
        m_led_o = 6'b111111;
        for (int n = 0; n < 6; n++) m_duty[n] = 0;
    endtask

    // One clock edge of the reference: phases are edge count modulo period.
    task automatic model_edge();
        int  pw;
        logic tick;
        if (!rstn) begin
            model_reset();
            return;
        end
        pw   = m_edges % 255;
        tick = ((m_edges % SD) == SD - 1);
        for (int n = 0; n < 6; n++) m_led_o[n] = !(pw < m_duty[n]);
        for (int n = 0; n < 6; n++) begin
            if (!fade_en)                       m_duty[n] = tgt(n);
            else if (tick && m_duty[n] < tgt(n)) m_duty[n] = m_duty[n] + 1;
            else if (tick && m_duty[n] > tgt(n)) m_duty[n] = m_duty[n] - 1;
        end
        m_led_q = led_i;
        m_edges++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        repeat (3) cyc();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; led_i = 6'b000000; fade_en = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++;
            if (led_o !== 6'b111111 || busy !== 1'b0)
                $display("FAIL reset_hold led_o=%b busy=%b want 111111/0", led_o, busy);
            else n_pass++;
        end
        rstn = 1'b1;
        led_i = 6'b111111;
        for (int i = 0; i < 300; i++) begin
            n_checks++;
            if (dut.pwm_cnt !== 8'(m_edges % 255))
                $display("FAIL reset_pwm_phase pwm_cnt=%0d want %0d", dut.pwm_cnt, m_edges % 255);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_snap();
        do_reset();
        fade_en = 1'b0;
        led_i   = 6'b111110;
        for (int i = 0; i < 600; i++) begin
            cyc();
            n_checks++;
            if (led_o !== m_led_o || busy !== m_busy())
                $display("FAIL snap led_o=%b busy=%b want %b/%b", led_o, busy, m_led_o, m_busy());
            else n_pass++;
            if (i >= 2) begin
                n_checks++;
                if (led_o !== 6'b111110 || busy !== 1'b0)
                    $display("FAIL snap_steady cyc=%0d led_o=%b busy=%b want 111110/0", i, led_o, busy);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fade_up();
        int  cnt;
        logic done;
        do_reset();
        fade_en = 1'b1;
        led_i   = 6'b111110;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 1100) begin
            cyc();
            cnt++;
            n_checks++;
            if (led_o !== m_led_o || busy !== m_busy())
                $display("FAIL fade_up led_o=%b busy=%b want %b/%b", led_o, busy, m_led_o, m_busy());
            else n_pass++;
            if (cnt > 2 && !busy) done = 1'b1;
        end
        n_checks++;
        if (!done || cnt < 1016 || cnt > 1024)
            $display("FAIL fade_up_time cycles=%0d want 1020+-4", cnt);
        else n_pass++;
        n_checks++;
        if (dut.duty[0] !== 8'd255)
            $display("FAIL fade_up_end duty0=%0d want 255", dut.duty[0]);
        else n_pass++;
        for (int i = 0; i < 300; i++) begin
            cyc();
            n_checks++;
            if (led_o !== 6'b111110 || busy !== 1'b0 || dut.duty[0] !== 8'd255)
                $display("FAIL fade_up_hold led_o=%b busy=%b duty0=%0d want 111110/0/255", led_o, busy, dut.duty[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reversal();
        int prev;
        int cnt;
        do_reset();
        fade_en = 1'b1;
        led_i   = 6'b111110;
        cnt = 0;
        while (m_duty[0] != 100 && cnt < 600) begin cyc(); cnt++; end
        n_checks++;
        if (dut.duty[0] !== 8'd100) $display("FAIL rev_peak duty0=%0d want 100", dut.duty[0]);
        else n_pass++;
        led_i = 6'b111111;
        prev  = 100;
        for (int i = 0; i < 800; i++) begin
            cyc();
            n_checks++;
            if (dut.duty[0] !== 8'(m_duty[0]) || led_o !== m_led_o || busy !== m_busy())
                $display("FAIL reversal duty0=%0d led_o=%b busy=%b want %0d/%b/%b",
                         dut.duty[0], led_o, busy, m_duty[0], m_led_o, m_busy());
            else n_pass++;
            n_checks++;
            if (prev - int'(dut.duty[0]) > 1 || int'(dut.duty[0]) > prev)
                $display("FAIL rev_no_jump duty0=%0d prev=%0d", dut.duty[0], prev);
            else n_pass++;
            prev = int'(dut.duty[0]);
        end
        n_checks++;
        if (dut.duty[0] !== 8'd0 || busy !== 1'b0)
            $display("FAIL rev_floor duty0=%0d busy=%b want 0/0", dut.duty[0], busy);
        else n_pass++;
    endtask

    task automatic test_running();
        logic [5:0] p;
        do_reset();
        fade_en = 1'b1;
        p = 6'b111110;
        for (int r = 0; r < 6; r++) begin
            led_i = p;
            for (int i = 0; i < 2000; i++) begin
                cyc();
                n_checks++;
                if (led_o !== m_led_o || busy !== m_busy())
                    $display("FAIL running r=%0d led_o=%b busy=%b want %b/%b", r, led_o, busy, m_led_o, m_busy());
                else n_pass++;
            end
            p = {p[4:0], p[5]};
        end
    endtask

    task automatic test_mode_switch();
        int cnt;
        do_reset();
        fade_en = 1'b1;
        led_i   = 6'b111110;
        cnt = 0;
        while (m_duty[0] != 37 && cnt < 400) begin cyc(); cnt++; end
        fade_en = 1'b0;
        cyc();
        n_checks++;
        if (dut.duty[0] !== 8'd255 || busy !== 1'b0)
            $display("FAIL mode_snap duty0=%0d busy=%b want 255/0", dut.duty[0], busy);
        else n_pass++;
        fade_en = 1'b1;
        led_i   = 6'b111101;
        repeat (200) cyc();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_fade_busy busy=%b want 1", busy);
        else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (led_o !== 6'b111111 || busy !== 1'b0 || dut.duty[1] !== 8'd0)
            $display("FAIL async_reset led_o=%b busy=%b duty1=%0d want 111111/0/0", led_o, busy, dut.duty[1]);
        else n_pass++;
        repeat (2) cyc();
        rstn = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 25; s++) begin
            led_i   = 6'($urandom_range(0, 63));
            fade_en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'($urandom_range(1, 300)); i++) begin
                cyc();
                n_checks++;
                if (led_o !== m_led_o || busy !== m_busy())
                    $display("FAIL random s=%0d led_o=%b busy=%b want %b/%b", s, led_o, busy, m_led_o, m_busy());
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_snap();
        test_fade_up();
        test_reversal();
        test_running();
        test_mode_switch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
